// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_e   : arbiter FSM encoding (IDLE=0, ACCESS=1, DONE=2)
//   port_e    : requester index (PORT_CPU=0, PORT_DBG=1)
//   rr_pick   : round-robin winner between the two pending ports
package dmem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_e;

  // On a tie the port not granted last wins; a lone pending port always wins.
  function automatic port_e rr_pick(input logic cpu_pend, input logic dbg_pend,
                                    input port_e last);
    if (cpu_pend && dbg_pend) return (last == PORT_CPU) ? PORT_DBG : PORT_CPU;
    else if (dbg_pend)        return PORT_DBG;
    else                      return PORT_CPU;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (CPU, debug loader), the arbiter
// and the synchronous data memory.
//   cpu_*/dbg_* : request (req/we/addr/wdata) in, busy/ack/rdata out
//   mem_*       : addr/wdata/wren/rden to memory, mem_q back (1-cycle latency)
// Modports: slave = arbiter side, master = requester/memory side.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) ();

  logic              cpu_req, cpu_we, cpu_busy, cpu_ack;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;

  logic              dbg_req, dbg_we, dbg_busy, dbg_ack;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_q;
  logic              mem_wren, mem_rden;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_q,
    output cpu_busy, cpu_ack, cpu_rdata,
    output dbg_busy, dbg_ack, dbg_rdata,
    output mem_addr, mem_wdata, mem_wren, mem_rden
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_q,
    input  cpu_busy, cpu_ack, cpu_rdata,
    input  dbg_busy, dbg_ack, dbg_rdata,
    input  mem_addr, mem_wdata, mem_wren, mem_rden
  );

endinterface

// File: rtl/dmem_req_slot.sv
// Per-port pending-request slot.
//   req_i/we_i/addr_i/wdata_i : request, accepted when not already pending
//   done_i                    : arbiter completing this port's transaction
//   mem_q_i                   : memory read data (valid in the done cycle)
//   pend_o/we_o/addr_o/wdata_o: latched command (pend_o doubles as busy)
//   ack_o/rdata_o             : completion pulse and load data
module dmem_req_slot #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              done_i,
  input  logic [DATA_W-1:0] mem_q_i,
  output logic              pend_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic              pend_q, pend_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              load_done;

  assign load_done = done_i && !we_q;

  // done_i only arrives while pending, so it never coincides with an accept.
  always_comb begin
    pend_d  = pend_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (req_i && !pend_q) begin
      pend_d  = 1'b1;
      we_d    = we_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end else if (done_i) begin
      pend_d = 1'b0;
    end
    if (load_done) rdata_d = mem_q_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign pend_o  = pend_q;
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign ack_o   = done_i;
  // Memory data only exists during the ack cycle, so it is forwarded
  // there and held in rdata_q afterwards.
  assign rdata_o = load_done ? mem_q_i : rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter (CPU, debug loader) in front of a single
// synchronous data memory.  Each transaction: IDLE (grant) -> ACCESS
// (one mem_wren/mem_rden cycle) -> DONE (ack, load data captured).
//   clk, rst : clock, synchronous active-low reset
//   bus      : dmem_arbiter_if.slave carrying cpu_*, dbg_* and mem_*
module dmem_arbiter import dmem_arbiter_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  logic [1:0]        pend, done, cmd_we;
  logic [ADDR_W-1:0] cmd_addr  [2];
  logic [DATA_W-1:0] cmd_wdata [2];

  dmem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cpu_slot (
    .clk(clk), .rst(rst),
    .req_i(bus.cpu_req), .we_i(bus.cpu_we), .addr_i(bus.cpu_addr), .wdata_i(bus.cpu_wdata),
    .done_i(done[PORT_CPU]), .mem_q_i(bus.mem_q),
    .pend_o(pend[PORT_CPU]), .we_o(cmd_we[PORT_CPU]),
    .addr_o(cmd_addr[PORT_CPU]), .wdata_o(cmd_wdata[PORT_CPU]),
    .ack_o(bus.cpu_ack), .rdata_o(bus.cpu_rdata)
  );

  dmem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dbg_slot (
    .clk(clk), .rst(rst),
    .req_i(bus.dbg_req), .we_i(bus.dbg_we), .addr_i(bus.dbg_addr), .wdata_i(bus.dbg_wdata),
    .done_i(done[PORT_DBG]), .mem_q_i(bus.mem_q),
    .pend_o(pend[PORT_DBG]), .we_o(cmd_we[PORT_DBG]),
    .addr_o(cmd_addr[PORT_DBG]), .wdata_o(cmd_wdata[PORT_DBG]),
    .ack_o(bus.dbg_ack), .rdata_o(bus.dbg_rdata)
  );

  assign bus.cpu_busy = pend[PORT_CPU];
  assign bus.dbg_busy = pend[PORT_DBG];

  state_e            state_q, state_d;
  port_e             grant_q, grant_d, last_q, last_d, pick;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;

  assign pick = rr_pick(pend[PORT_CPU], pend[PORT_DBG], last_q);

  // State register (grant bookkeeping and memory address/data ride along).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= PORT_CPU;
      last_q   <= PORT_DBG;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|pend) begin
          state_d  = ST_ACCESS;
          grant_d  = pick;
          last_d   = pick;
          maddr_d  = cmd_addr[pick];
          mwdata_d = cmd_wdata[pick];
        end
      end
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.mem_wren = 1'b0;
    bus.mem_rden = 1'b0;
    done         = '0;
    case (state_q)
      ST_ACCESS: begin
        bus.mem_wren = cmd_we[grant_q];
        bus.mem_rden = !cmd_we[grant_q];
      end
      ST_DONE: done[grant_q] = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// random traffic, every cycle compared against a transaction-level model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Synchronous data memory attached to the arbiter.
  logic [DW-1:0] tb_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_wren) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rden) bus.mem_q <= tb_mem[bus.mem_addr];
  end

  function automatic logic [DW-1:0] init_word(input int unsigned i);
    return 32'hA5C30000 ^ (i * 32'h00010203);
  endfunction

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction timestamps) ----------------
  typedef struct {
    bit            v;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  cmd_t          pend [2];
  logic [DW-1:0] rd [2];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            act;       // a transaction has been granted
  int            act_p;     // its port
  longint        act_g;     // cycle in which it was granted
  int            lg;        // last granted port
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  longint        cyc = 0;
  bit            chk_en = 1'b0;
  bit            e_acc, e_ack;
  bit            x_ack [2];
  logic [DW-1:0] x_rd [2];

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      pend[p] = '{v: 1'b0, we: 1'b0, a: '0, d: '0};
      rd[p]   = '0;
    end
    act = 1'b0; act_p = 0; act_g = 0; lg = 1; m_a = '0; m_d = '0;
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_edge();
    bit old_v [2];
    bit req [2];
    int w;
    old_v[0] = pend[0].v; old_v[1] = pend[1].v;
    req[0] = bus.cpu_req; req[1] = bus.dbg_req;
    if (e_acc && pend[act_p].we) ref_mem[pend[act_p].a] = pend[act_p].d;
    if (!rst) begin
      model_reset();
    end else begin
      if (e_ack) begin
        if (!pend[act_p].we) rd[act_p] = ref_mem[pend[act_p].a];
        pend[act_p].v = 1'b0;
        act = 1'b0;
      end else if (!act && (old_v[0] || old_v[1])) begin
        if (old_v[0] && old_v[1]) w = 1 - lg;
        else w = old_v[0] ? 0 : 1;
        act = 1'b1; act_p = w; act_g = cyc; lg = w;
        m_a = pend[w].a; m_d = pend[w].d;
      end
      if (req[0] && !old_v[0]) pend[0] = '{v: 1'b1, we: bus.cpu_we, a: bus.cpu_addr, d: bus.cpu_wdata};
      if (req[1] && !old_v[1]) pend[1] = '{v: 1'b1, we: bus.dbg_we, a: bus.dbg_addr, d: bus.dbg_wdata};
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      e_acc = act && (cyc == act_g + 1);
      e_ack = act && (cyc == act_g + 2);
      for (int p = 0; p < 2; p++) begin
        x_ack[p] = e_ack && (act_p == p);
        x_rd[p]  = (x_ack[p] && !pend[p].we) ? ref_mem[pend[p].a] : rd[p];
      end
      check_eq("cpu_busy",  bus.cpu_busy,  pend[0].v);
      check_eq("dbg_busy",  bus.dbg_busy,  pend[1].v);
      check_eq("cpu_ack",   bus.cpu_ack,   x_ack[0]);
      check_eq("dbg_ack",   bus.dbg_ack,   x_ack[1]);
      check_eq("cpu_rdata", bus.cpu_rdata, x_rd[0]);
      check_eq("dbg_rdata", bus.dbg_rdata, x_rd[1]);
      check_eq("mem_wren",  bus.mem_wren,  e_acc && pend[act_p].we);
      check_eq("mem_rden",  bus.mem_rden,  e_acc && !pend[act_p].we);
      check_eq("mem_addr",  bus.mem_addr,  m_a);
      check_eq("mem_wdata", bus.mem_wdata, m_d);
      model_edge();
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic next_neg();
    step(); @(negedge clk);
  endtask

  task automatic clr_req();
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
  endtask

  task automatic cpu_cmd(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic dbg_cmd(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask

  initial begin
    for (int unsigned i = 0; i < (1 << AW); i++) begin
      tb_mem[i]  = init_word(i);
      ref_mem[i] = init_word(i);
    end
    model_reset();
    clr_req();
    bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    rst = 1'b0;
    step(); step();
    chk_en = 1'b1;            // reset state checked in this cycle
    step(); rst = 1'b1;

    // Store 5 <- DEADBEEF, uncontended.
    step(); cpu_cmd(1'b1, 12'd5, 32'hDEADBEEF);
    step(); clr_req();
    next_neg();
    check_eq("st_wren_T2",  bus.mem_wren, 1'b1);
    check_eq("st_addr_T2",  bus.mem_addr, 12'd5);
    check_eq("st_wdata_T2", bus.mem_wdata, 32'hDEADBEEF);
    next_neg();
    check_eq("st_ack_T3",   bus.cpu_ack, 1'b1);
    check_eq("st_rdata_T3", bus.cpu_rdata, 32'h0);

    // Load 5 back.
    step(); cpu_cmd(1'b0, 12'd5, '0);
    step(); clr_req();
    next_neg();
    check_eq("ld_rden_T2",  bus.mem_rden, 1'b1);
    next_neg();
    check_eq("ld_ack_T3",   bus.cpu_ack, 1'b1);
    check_eq("ld_rdata_T3", bus.cpu_rdata, 32'hDEADBEEF);

    // Simultaneous loads out of reset: CPU first.
    step(); rst = 1'b0;
    step(); rst = 1'b1;
    step(); cpu_cmd(1'b0, 12'd5, '0); dbg_cmd(1'b0, 12'd6, '0);
    step(); clr_req();
    next_neg(); next_neg();
    check_eq("tie1_cpu_ack", bus.cpu_ack, 1'b1);
    check_eq("tie1_dbg_ack", bus.dbg_ack, 1'b0);
    check_eq("tie1_cpu_rd",  bus.cpu_rdata, 32'hDEADBEEF);
    next_neg(); next_neg(); next_neg();
    check_eq("tie1_dbg_ack6", bus.dbg_ack, 1'b1);
    check_eq("tie1_dbg_rd",   bus.dbg_rdata, init_word(6));
    // CPU alone, then a tie goes to DBG.
    step(); cpu_cmd(1'b0, 12'd1, '0);
    step(); clr_req();
    next_neg(); next_neg();
    step(); cpu_cmd(1'b0, 12'd2, '0); dbg_cmd(1'b0, 12'd3, '0);
    step(); clr_req();
    next_neg(); next_neg();
    check_eq("tie2_dbg_ack", bus.dbg_ack, 1'b1);
    check_eq("tie2_cpu_ack", bus.cpu_ack, 1'b0);
    next_neg(); next_neg(); next_neg();
    check_eq("tie2_cpu_ack6", bus.cpu_ack, 1'b1);

    // Store to 9 while busy is dropped.
    step(); cpu_cmd(1'b1, 12'd3, 32'h33333333);
    step(); cpu_cmd(1'b1, 12'd9, 32'h99999999);
    step(); clr_req();
    repeat (6) step();
    check_eq("busy_drop_mem9", tb_mem[9], init_word(9));

    // Reset in the ACCESS cycle of a store.
    step(); cpu_cmd(1'b1, 12'd7, 32'h77777777);
    step(); clr_req();
    step(); rst = 1'b0;
    @(negedge clk);
    check_eq("rst_acc_wren", bus.mem_wren, 1'b1);
    step(); rst = 1'b1;
    @(negedge clk);
    check_eq("rst_ack",  bus.cpu_ack, 1'b0);
    check_eq("rst_busy", bus.cpu_busy, 1'b0);
    check_eq("rst_wren", bus.mem_wren, 1'b0);
    step(); cpu_cmd(1'b0, 12'd5, '0);
    step(); clr_req();
    next_neg(); next_neg();
    check_eq("post_rst_ack", bus.cpu_ack, 1'b1);
    check_eq("post_rst_rd",  bus.cpu_rdata, 32'hDEADBEEF);

    // Back-to-back loads, second pulsed the cycle after the first ack.
    step(); cpu_cmd(1'b0, 12'd5, '0);
    step(); clr_req();
    next_neg(); next_neg();
    check_eq("b2b_ack1", bus.cpu_ack, 1'b1);
    step(); cpu_cmd(1'b0, 12'd6, '0);
    step(); clr_req();
    next_neg();
    check_eq("b2b_ack_gap", bus.cpu_ack, 1'b0);
    next_neg();
    check_eq("b2b_ack2", bus.cpu_ack, 1'b1);
    check_eq("b2b_rd2",  bus.cpu_rdata, init_word(6));

    // Random traffic on a small address window.
    for (int k = 0; k < 2000; k++) begin
      step();
      bus.cpu_req   = ($urandom_range(0, 2) == 0);
      bus.cpu_we    = $urandom_range(0, 1) == 1;
      bus.cpu_addr  = AW'($urandom_range(0, 15));
      bus.cpu_wdata = $urandom;
      bus.dbg_req   = ($urandom_range(0, 2) == 0);
      bus.dbg_we    = $urandom_range(0, 1) == 1;
      bus.dbg_addr  = AW'($urandom_range(0, 15));
      bus.dbg_wdata = $urandom;
    end
    step(); clr_req();
    repeat (10) step();
    for (int unsigned i = 0; i < 16; i++) check_eq("mem_final", tb_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
